// File: rtl/spi_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_sched_pkg
// Description : Shared state encoding and default widths for spi_xfer_sched.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_sched_pkg;

    localparam int c_N_DEF       = 8;
    localparam int c_R_DEF       = 3;
    localparam int c_BACKOFF_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_WAIT    = 3'd2,
        ST_ABORT   = 3'd3,
        ST_BACKOFF = 3'd4,
        ST_DONE    = 3'd5,
        ST_FAIL    = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/xfer_timer.sv
`default_nettype none
// ============================================================================
// Module      : xfer_timer
// Description : Loadable down-counter that stops at zero, with a zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
module xfer_timer #(
    parameter int W = 8
) (
    input  logic         i_clk_p,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    localparam logic [W-1:0] c_ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] r_count;

    // Load wins over decrement so a reload is never lost to a pending count.
    always_ff @(posedge i_clk_p or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - c_ONE;
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/spi_xfer_sched.sv
`default_nettype none
// ============================================================================
// Module      : spi_xfer_sched
// Description : Launches SPI attempts with per-attempt timeout, abort, backoff
//               and bounded retry; reports success or exhaustion.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_xfer_sched
    import spi_sched_pkg::*;
#(
    parameter int N       = c_N_DEF,
    parameter int R       = c_R_DEF,
    parameter int BACKOFF = c_BACKOFF_DEF
) (
    input  logic         i_clk_p,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [N-1:0] i_timeout,
    input  logic [R-1:0] i_retries,
    input  logic         i_spi_done,
    output logic         o_spi_start,
    output logic         o_spi_abort,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_fail,
    output logic [R:0]   o_attempts
);

    localparam logic [3:0] c_BO_LOAD = 4'(BACKOFF - 1);
    localparam logic [R:0] c_ATT_ONE = {{R{1'b0}}, 1'b1};
    localparam logic [R:0] c_ATT_MAX = '1;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [N-1:0] r_timeout;
    logic [R-1:0] r_retries;
    logic [R:0]   r_attempts;
    logic         w_capture;
    logic         w_inc;
    logic         w_tmr_load;
    logic         w_tmr_dec;
    logic         w_tmr_zero;
    logic         w_bo_load;
    logic         w_bo_dec;
    logic         w_bo_zero;

    xfer_timer #(.W(N)) u_attempt_timer (
        .i_clk_p    (i_clk_p),
        .i_rst      (i_rst),
        .i_load     (w_tmr_load),
        .i_load_val (r_timeout),
        .i_dec      (w_tmr_dec),
        .o_zero     (w_tmr_zero)
    );

    // Backoff counter loads BACKOFF-1 in ABORT so BACKOFF spans exactly BACKOFF cycles.
    xfer_timer #(.W(4)) u_backoff_timer (
        .i_clk_p    (i_clk_p),
        .i_rst      (i_rst),
        .i_load     (w_bo_load),
        .i_load_val (c_BO_LOAD),
        .i_dec      (w_bo_dec),
        .o_zero     (w_bo_zero)
    );

    always_ff @(posedge i_clk_p or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_inc       = 1'b0;
        w_tmr_load  = 1'b0;
        w_tmr_dec   = 1'b0;
        w_bo_load   = 1'b0;
        w_bo_dec    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_ARM;
                end
            end
            ST_ARM: begin
                w_inc       = 1'b1;
                w_tmr_load  = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                w_tmr_dec = 1'b1;
                if (i_spi_done) begin
                    w_state_nxt = ST_DONE;
                end else if (w_tmr_zero && (r_timeout != '0)) begin
                    w_state_nxt = ST_ABORT;
                end
            end
            ST_ABORT: begin
                w_bo_load   = 1'b1;
                w_state_nxt = (r_attempts <= {1'b0, r_retries}) ? ST_BACKOFF : ST_FAIL;
            end
            ST_BACKOFF: begin
                w_bo_dec = 1'b1;
                if (w_bo_zero) begin
                    w_state_nxt = ST_ARM;
                end
            end
            ST_DONE, ST_FAIL: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk_p or posedge i_rst) begin
        if (i_rst) begin
            r_timeout  <= '0;
            r_retries  <= '0;
            r_attempts <= '0;
        end else if (w_capture) begin
            r_timeout  <= i_timeout;
            r_retries  <= i_retries;
            r_attempts <= '0;
        end else if (w_inc && (r_attempts != c_ATT_MAX)) begin
            r_attempts <= r_attempts + c_ATT_ONE;
        end
    end

    assign o_spi_start = (r_state == ST_ARM);
    assign o_spi_abort = (r_state == ST_ABORT);
    assign o_busy      = (r_state != ST_IDLE);
    assign o_done      = (r_state == ST_DONE);
    assign o_fail      = (r_state == ST_FAIL);
    assign o_attempts  = r_attempts;

endmodule
`default_nettype wire

// File: tb/tb_spi_xfer_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_spi_xfer_sched
// Description : Scoreboard bench for spi_xfer_sched with a closed-form timing model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_xfer_sched;

    localparam int N       = 8;
    localparam int R       = 3;
    localparam int BACKOFF = 2;

    // Per-attempt done delay in WAIT cycles after the launch pulse; 0 = never.
    typedef logic [7:0][7:0] plan_t;
    typedef struct {
        int acc;
        int t;
        int n_att;
        bit ok;
        int fin;
    } exp_t;

    logic         i_clk_p    = 1'b0;
    logic         i_rst      = 1'b1;
    logic         i_start    = 1'b0;
    logic [N-1:0] i_timeout  = '0;
    logic [R-1:0] i_retries  = '0;
    logic         i_spi_done = 1'b0;
    logic         o_spi_start;
    logic         o_spi_abort;
    logic         o_busy;
    logic         o_done;
    logic         o_fail;
    logic [R:0]   o_attempts;

    int    cyc        = 0;
    int    compared   = 0;
    int    mismatched = 0;
    int    done_at    = -1;
    exp_t  exp_q[$];
    plan_t plan_q[$];

    spi_xfer_sched #(.N(N), .R(R), .BACKOFF(BACKOFF)) dut (
        .i_clk_p     (i_clk_p),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_timeout   (i_timeout),
        .i_retries   (i_retries),
        .i_spi_done  (i_spi_done),
        .o_spi_start (o_spi_start),
        .o_spi_abort (o_spi_abort),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_fail      (o_fail),
        .o_attempts  (o_attempts)
    );

    always #5 i_clk_p = ~i_clk_p;
    always @(posedge i_clk_p) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Attempt period = ARM + (T+1) WAIT + ABORT + BACKOFF; cycle 0 is the IDLE cycle holding i_start.
    function automatic exp_t model(input int acc, input int t, input int r, input plan_t p);
        exp_t e;
        int   per;
        int   d;
        per     = t + 3 + BACKOFF;
        e.acc   = acc;
        e.t     = t;
        e.ok    = 1'b0;
        e.n_att = r + 1;
        e.fin   = acc + r * per + t + 4;
        for (int a = 0; a <= r; a++) begin
            d = int'(p[a]);
            if (d != 0 && (t == 0 || d <= t + 1)) begin
                e.ok    = 1'b1;
                e.n_att = a + 1;
                e.fin   = acc + a * per + d + 2;
                return e;
            end
        end
        return e;
    endfunction

    function automatic plan_t rand_plan(input int t);
        plan_t p;
        int    m;
        p = '0;
        for (int a = 0; a < 8; a++) begin
            m = int'($urandom_range(0, 2));
            if (t == 0)       p[a] = 8'($urandom_range(1, 12));
            else if (m == 1)  p[a] = 8'($urandom_range(1, t + 1));
            else if (m == 2)  p[a] = 8'(t + 2 + int'($urandom_range(0, 1)));
            else              p[a] = 8'd0;
        end
        return p;
    endfunction

    // Responder: plays the SPI unit, answering each launch according to its plan.
    initial begin : responder
        plan_t cur;
        int    idx;
        bit    act;
        cur = '0;
        idx = 0;
        act = 1'b0;
        forever begin
            @(negedge i_clk_p);
            if (i_rst) begin
                act     = 1'b0;
                done_at = -1;
            end else begin
                if (o_spi_start) begin
                    if (!act && plan_q.size() > 0) begin
                        cur = plan_q.pop_front();
                        act = 1'b1;
                        idx = 0;
                    end
                    if (act && idx < 8) begin
                        if (cur[idx[2:0]] != 8'd0) done_at = cyc + int'(cur[idx[2:0]]);
                        idx++;
                    end
                end
                if (o_done || o_fail) act = 1'b0;
            end
        end
    end

    initial begin : done_driver
        forever begin
            @(posedge i_clk_p);
            #1;
            i_spi_done = (cyc == done_at);
        end
    end

    initial begin : monitor
        exp_t e;
        int   n_st;
        int   n_ab;
        int   last_att;
        bit   exp_busy;
        n_st     = 0;
        n_ab     = 0;
        last_att = 0;
        forever begin
            @(negedge i_clk_p);
            if (i_rst) begin
                n_st     = 0;
                n_ab     = 0;
                last_att = 0;
            end else begin
                exp_busy = (exp_q.size() > 0) && (cyc > exp_q[0].acc) && (cyc <= exp_q[0].fin);
                check("busy", int'(o_busy), int'(exp_busy));
                if (exp_q.size() == 0) check("attempts_held", int'(o_attempts), last_att);
                if (o_spi_start) begin
                    if (exp_q.size() == 0) check("unexpected_spi_start", 1, 0);
                    else check("spi_start_cycle", cyc,
                               exp_q[0].acc + 1 + n_st * (exp_q[0].t + 3 + BACKOFF));
                    n_st++;
                end
                if (o_spi_abort) n_ab++;
                if (o_done || o_fail) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_end", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("done_flag", int'(o_done), int'(e.ok));
                        check("fail_flag", int'(o_fail), int'(!e.ok));
                        check("end_cycle", cyc, e.fin);
                        check("attempts", int'(o_attempts), e.n_att);
                        check("start_count", n_st, e.n_att);
                        check("abort_count", n_ab, e.ok ? e.n_att - 1 : e.n_att);
                        last_att = e.n_att;
                    end
                    n_st = 0;
                    n_ab = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge i_clk_p);
        #1;
    endtask

    task automatic do_reset();
        #1;
        i_rst = 1'b1;
        exp_q.delete();
        plan_q.delete();
        tick();
        tick();
        i_rst = 1'b0;
    endtask

    task automatic wait_quiet();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || o_busy) && k < 2000) begin
            tick();
            k++;
        end
        if (k >= 2000) begin
            check("transfer_timeout", k, 0);
            do_reset();
        end
    endtask

    task automatic run_xfer(input int t, input int r, input plan_t p, input bit hold, input int gap);
        exp_t e1;
        exp_t e2;
        wait_quiet();
        repeat (gap) tick();
        i_timeout = N'(t);
        i_retries = R'(r);
        i_start   = 1'b1;
        e1 = model(cyc, t, r, p);
        plan_q.push_back(p);
        exp_q.push_back(e1);
        if (hold) begin
            e2 = model(e1.fin + 1, t, r, p);
            plan_q.push_back(p);
            exp_q.push_back(e2);
            while (cyc < e1.fin + 2) tick();
        end else begin
            tick();
        end
        i_start = 1'b0;
    endtask

    initial begin : stimulus
        plan_t p;
        int    k;
        int    t;
        tick();
        tick();
        check("rst_busy", int'(o_busy), 0);
        check("rst_start", int'(o_spi_start), 0);
        check("rst_attempts", int'(o_attempts), 0);
        i_rst = 1'b0;

        p = '0; p[0] = 8'd3;
        run_xfer(5, 2, p, 1'b0, 0);
        p = '0;
        run_xfer(5, 2, p, 1'b0, 1);
        p = '0; p[0] = 8'd6;
        run_xfer(5, 2, p, 1'b0, 2);
        p = '0; p[0] = 8'd100;
        run_xfer(0, 1, p, 1'b0, 0);
        p = '0; p[0] = 8'd7; p[1] = 8'd6;
        run_xfer(5, 2, p, 1'b0, 1);
        p = '0;
        run_xfer(1, 0, p, 1'b0, 0);

        // Asynchronous reset in the WAIT phase of the second attempt.
        p = '0;
        run_xfer(5, 2, p, 1'b0, 0);
        k = 0;
        while (k < 200 && !(o_spi_start && o_attempts == 1)) begin
            tick();
            k++;
        end
        check("reach_second_arm", int'(k < 200), 1);
        tick();
        tick();
        check("attempts_before_rst", int'(o_attempts), 2);
        #1;
        i_rst = 1'b1;
        #1;
        check("arst_busy", int'(o_busy), 0);
        check("arst_outputs", int'({o_spi_start, o_spi_abort, o_done, o_fail}), 0);
        check("arst_attempts", int'(o_attempts), 0);
        exp_q.delete();
        plan_q.delete();
        tick();
        tick();
        i_rst = 1'b0;
        p = '0; p[0] = 8'd2;
        run_xfer(3, 1, p, 1'b0, 0);

        p = '0; p[0] = 8'd4;
        run_xfer(5, 1, p, 1'b1, 1);

        for (int n = 0; n < 40; n++) begin
            t = int'($urandom_range(0, 7));
            run_xfer(t, int'($urandom_range(0, 3)), rand_plan(t), 1'b0, int'($urandom_range(0, 2)));
        end

        wait_quiet();
        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
